// File: rtl/sr_sched_pkg.sv
// rtl/sr_sched_pkg.sv - shared types and helpers for the SR flag scheduler
package sr_sched_pkg;

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

  localparam logic OP_CLR = 1'b0;
  localparam logic OP_SET = 1'b1;

  function automatic int calc_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   win
);

  function automatic logic [PTR_W-1:0] wrap(input int v);
    return PTR_W'(v % NUM_REQ);
  endfunction

  logic found;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (en && !found && req[wrap(int'(ptr) + k)]) begin
        found = 1'b1;
        win   = wrap(int'(ptr) + k);
        gnt[wrap(int'(ptr) + k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_flag_scheduler.sv
// rtl/sr_flag_scheduler.sv - round-robin SR flag command sequencer with reset clear sweep
// Optional: SR_SCHED_COALESCE_EN suppresses commands that would not change the flag.
module sr_flag_scheduler
  import sr_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_FLAGS = 8,
  localparam int IDX_W    = calc_idx_w(NUM_FLAGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_set,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  input  logic                     hold,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_FLAGS-1:0]     cmd_en,
  output logic                     cmd_s,
  output logic                     cmd_r,
  output logic [NUM_FLAGS-1:0]     flags,
  output logic                     init_done,
  output logic                     idx_err
);

  localparam int PTR_W = (NUM_REQ < 2) ? 1 : $clog2(NUM_REQ);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     cnt, cnt_nxt;
  logic [PTR_W-1:0]     ptr, ptr_nxt, win;
  logic [NUM_FLAGS-1:0] en_nxt, flags_nxt;
  logic                 s_nxt, r_nxt, done_nxt, err_nxt;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_set, in_range, redundant, any_gnt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  ((state == ST_RUN) && !hold),
    .gnt (req_ready),
    .win (win)
  );

  assign any_gnt  = |req_ready;
  assign win_set  = req_set[win];
  assign win_idx  = req_idx[int'(win)*IDX_W +: IDX_W];
  assign in_range = int'(win_idx) < NUM_FLAGS;

`ifdef SR_SCHED_COALESCE_EN
  assign redundant = in_range && (flags[win_idx] == win_set);
`else
  assign redundant = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    en_nxt    = '0;
    s_nxt     = 1'b0;
    r_nxt     = 1'b0;
    flags_nxt = flags;
    done_nxt  = init_done;
    err_nxt   = 1'b0;
    case (state)
      ST_INIT: begin
        // flag flops have no reset, so clear each one in turn
        en_nxt  = NUM_FLAGS'(1) << cnt;
        r_nxt   = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (int'(cnt) == NUM_FLAGS - 1) begin
          state_nxt = ST_RUN;
          done_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        if (any_gnt) begin
          ptr_nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
          if (!in_range) begin
            err_nxt = 1'b1;
          end else if (!redundant) begin
            en_nxt             = NUM_FLAGS'(1) << win_idx;
            s_nxt              = (win_set == OP_SET);
            r_nxt              = (win_set == OP_CLR);
            flags_nxt[win_idx] = win_set;
          end
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      ptr       <= '0;
      cmd_en    <= '0;
      cmd_s     <= 1'b0;
      cmd_r     <= 1'b0;
      flags     <= '0;
      init_done <= 1'b0;
      idx_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      cmd_en    <= en_nxt;
      cmd_s     <= s_nxt;
      cmd_r     <= r_nxt;
      flags     <= flags_nxt;
      init_done <= done_nxt;
      idx_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sr_flag_scheduler.sv
// tb/tb_sr_flag_scheduler.sv - scoreboard bench for sr_flag_scheduler (8-flag and 6-flag builds)
module tb_sr_flag_scheduler;

`ifdef SR_SCHED_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_set = '0;
  logic [11:0] req_idx = '0;
  logic        hold = 1'b0;
  logic [3:0]  req_ready;
  logic [7:0]  cmd_en, flags;
  logic        cmd_s, cmd_r, init_done, idx_err;

  logic [1:0]  v6 = '0;
  logic [1:0]  set6 = '0;
  logic [5:0]  idx6 = '0;
  logic        hold6 = 1'b0;
  logic [1:0]  rdy6;
  logic [5:0]  en6, flags6;
  logic        s6, r6, done6, err6;

  int checks = 0;
  int errors = 0;

  logic [19:0] sb_q[$];
  bit          m_run;
  int          m_cnt, m_ptr;
  logic [7:0]  m_flags;
  logic        m_done;

  always #5 clk = ~clk;

  sr_flag_scheduler #(.NUM_REQ(4), .NUM_FLAGS(8)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_set(req_set), .req_idx(req_idx),
    .hold(hold), .req_ready(req_ready), .cmd_en(cmd_en), .cmd_s(cmd_s), .cmd_r(cmd_r),
    .flags(flags), .init_done(init_done), .idx_err(idx_err)
  );

  sr_flag_scheduler #(.NUM_REQ(2), .NUM_FLAGS(6)) u_dut6 (
    .clk(clk), .rst(rst), .req_valid(v6), .req_set(set6), .req_idx(idx6),
    .hold(hold6), .req_ready(rdy6), .cmd_en(en6), .cmd_s(s6), .cmd_r(r6),
    .flags(flags6), .init_done(done6), .idx_err(err6)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run   = 1'b0;
    m_cnt   = 0;
    m_ptr   = 0;
    m_flags = '0;
    m_done  = 1'b0;
    sb_q.delete();
  endtask

  // One clock of the 8-flag DUT: predict, check grant, push expectation, pop after the edge.
  task automatic cycle();
    logic [3:0]  e_rdy;
    logic [7:0]  e_en;
    logic        e_s, e_r;
    logic [2:0]  idx;
    logic [19:0] got;
    int          w;
    e_rdy = '0; e_en = '0; e_s = 1'b0; e_r = 1'b0;
    @(negedge clk);
    if (!m_run) begin
      e_en = 8'h01 << m_cnt;
      e_r  = 1'b1;
      if (m_cnt == 7) begin
        m_run  = 1'b1;
        m_done = 1'b1;
      end
      m_cnt++;
    end else if (!hold && req_valid != 4'b0) begin
      w = m_ptr;
      while (!req_valid[w]) w = (w + 1) % 4;
      e_rdy[w] = 1'b1;
      idx      = req_idx[w*3 +: 3];
      m_ptr    = (w + 1) % 4;
      if (!(COALESCE && (m_flags[idx] == req_set[w]))) begin
        e_en         = 8'h01 << idx;
        e_s          = req_set[w];
        e_r          = !req_set[w];
        m_flags[idx] = req_set[w];
      end
    end
    check("req_ready", {28'b0, req_ready}, {28'b0, e_rdy});
    sb_q.push_back({e_en, e_s, e_r, m_flags, m_done, 1'b0});
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("cmd_en", {24'b0, cmd_en}, {24'b0, got[19:12]});
    check("cmd_s", {31'b0, cmd_s}, {31'b0, got[11]});
    check("cmd_r", {31'b0, cmd_r}, {31'b0, got[10]});
    check("flags", {24'b0, flags}, {24'b0, got[9:2]});
    check("init_done", {31'b0, init_done}, {31'b0, got[1]});
    check("idx_err", {31'b0, idx_err}, {31'b0, got[0]});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0001;
    req_set   = 4'b0001;
    req_idx   = {3'd7, 3'd0, 3'd5, 3'd3};
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_en", {24'b0, cmd_en}, 32'h0);
    check("rst_cmd_sr", {30'b0, cmd_s, cmd_r}, 32'h0);
    check("rst_flags", {24'b0, flags}, 32'h0);
    check("rst_done_err", {30'b0, init_done, idx_err}, 32'h0);
    check("rst_ready", {28'b0, req_ready}, 32'h0);
    rst = 1'b0;
    model_reset();

    // clear sweep; req0 is already pending and must wait for it
    repeat (8) cycle();
    check("sweep_done", {31'b0, init_done}, 32'h1);
    check("sweep_flags", {24'b0, flags}, 32'h0);

    // req0 set idx 3, granted in the first RUN cycle
    cycle();
    check("set3_en", {24'b0, cmd_en}, 32'h08);
    check("set3_s", {31'b0, cmd_s}, 32'h1);
    check("set3_flags", {24'b0, flags}, 32'h08);
    req_valid = 4'b0000;
    cycle();

    // all four requesters continuously valid
    req_valid = 4'b1111;
    req_set   = 4'b1110;
    req_idx   = {3'd7, 3'd0, 3'd5, 3'd1};
    repeat (5) cycle();

    // hold blocks grants for three cycles, then req1 wins
    req_valid = 4'b0010;
    hold      = 1'b1;
    repeat (3) cycle();
    hold = 1'b0;
    cycle();

    // redundant set of idx 3
    req_valid = 4'b0100;
    req_set   = 4'b0100;
    req_idx   = {3'd0, 3'd3, 3'd0, 3'd0};
    cycle();
    check("redund_en", {24'b0, cmd_en}, COALESCE ? 32'h00 : 32'h08);
    req_valid = 4'b0000;
    cycle();

    // back-to-back set then clear of flag 6
    req_valid = 4'b0011;
    req_set   = 4'b0001;
    req_idx   = {3'd0, 3'd0, 3'd6, 3'd6};
    repeat (2) cycle();
    check("b2b_flag6", {31'b0, flags[6]}, 32'h0);

    // reset one cycle after a grant
    req_valid = 4'b0001;
    req_set   = 4'b0001;
    req_idx   = {3'd0, 3'd0, 3'd0, 3'd4};
    cycle();
    rst = 1'b1;
    #1;
    check("mid_rst_en", {24'b0, cmd_en}, 32'h0);
    check("mid_rst_flags", {24'b0, flags}, 32'h0);
    check("mid_rst_done", {31'b0, init_done}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (8) cycle();
    req_valid = 4'b0000;

    // 6-flag build: in-range set, then out-of-range idx 7
    check("d6_done", {31'b0, done6}, 32'h1);
    check("d6_flags0", {26'b0, flags6}, 32'h0);
    v6   = 2'b01;
    set6 = 2'b11;
    idx6 = {3'd7, 3'd2};
    @(negedge clk);
    check("d6_rdy0", {30'b0, rdy6}, 32'h1);
    @(posedge clk);
    #1;
    check("d6_en2", {26'b0, en6}, 32'h04);
    check("d6_flags2", {26'b0, flags6}, 32'h04);
    check("d6_err0", {31'b0, err6}, 32'h0);
    v6 = 2'b10;
    @(negedge clk);
    check("d6_rdy1", {30'b0, rdy6}, 32'h2);
    @(posedge clk);
    #1;
    check("d6_err", {31'b0, err6}, 32'h1);
    check("d6_oor_en", {26'b0, en6}, 32'h0);
    check("d6_oor_sr", {30'b0, s6, r6}, 32'h0);
    check("d6_oor_flags", {26'b0, flags6}, 32'h04);
    v6 = 2'b00;
    @(posedge clk);
    #1;
    check("d6_err_pulse", {31'b0, err6}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
